// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel input debouncer with synchroniser, rise/fall pulses and any-change flag
`timescale 1ns/1ps
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int COUNT_WIDTH   = 16,
    parameter int STABLE_CYCLES = 65535,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] data_in,
    output logic [CHANNELS-1:0] data_debounced,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] busy,
    output logic                any_change
);

    if (STABLE_CYCLES < 1 ||
        longint'(STABLE_CYCLES) > ((longint'(1) << COUNT_WIDTH) - 1)) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES out of range for COUNT_WIDTH");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be at least 2");
    end

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(STABLE_CYCLES - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                   deb_q, deb_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   sync;

        assign sync = sync_q[SYNC_STAGES-1];

        // A single cycle of agreement with the debounced level wipes all progress.
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], data_in[i]};
            cnt_d  = cnt_q;
            deb_d  = deb_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (sync == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST_COUNT) begin
                cnt_d  = '0;
                deb_d  = sync;
                rise_d = sync;
                fall_d = ~sync;
            end else begin
                cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL}};
                cnt_q  <= '0;
                deb_q  <= RESET_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                deb_q  <= deb_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign data_debounced[i] = deb_q;
        assign rise_pulse[i]     = rise_q;
        assign fall_pulse[i]     = fall_q;
        assign busy[i]           = (cnt_q != '0);
    end

    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed self-checking bench for debounce_multi
`timescale 1ns/1ps
module tb_debounce_multi;

    localparam int LONG_CYCLES = 30000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data_in = 4'b0000;
    logic [3:0] deb, rise, fall, busy;
    logic       any;

    logic       din2 = 1'b0;
    logic [0:0] deb2, rise2, fall2, busy2;
    logic       any2;

    int checks = 0;
    int errors = 0;
    int rise2_cnt = 0;
    int fall2_cnt = 0;

    always #10 clk = ~clk;

    debounce_multi #(
        .CHANNELS(4), .COUNT_WIDTH(16), .STABLE_CYCLES(8), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_debounced(deb),
        .rise_pulse(rise), .fall_pulse(fall), .busy(busy), .any_change(any)
    );

    debounce_multi #(
        .CHANNELS(1), .COUNT_WIDTH(16), .STABLE_CYCLES(LONG_CYCLES), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .data_in(din2), .data_debounced(deb2),
        .rise_pulse(rise2), .fall_pulse(fall2), .busy(busy2), .any_change(any2)
    );

    always @(negedge clk) begin
        if (rise2[0]) rise2_cnt++;
        if (fall2[0]) fall2_cnt++;
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({deb, rise, fall, busy, any} !== 17'd0) begin
                errors++;
                $display("FAIL reset_hold: outputs=%h expected 0", {deb, rise, fall, busy, any});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({deb, rise, fall, busy, any} !== 17'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%h expected 0", i, {deb, rise, fall, busy, any});
            end
        end
    endtask

    task automatic test_bounce_rise();
        @(negedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            #0.5 data_in[0] = ~data_in[0];
        end
        data_in[0] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i <= 9) begin
                checks++;
                if (deb !== 4'b0000 || rise !== 4'b0000) begin
                    errors++;
                    $display("FAIL bounce_early i=%0d: deb=%b rise=%b expected 0000/0000", i, deb, rise);
                end
            end
            if (i == 9) begin
                checks++;
                if (busy !== 4'b0001) begin
                    errors++;
                    $display("FAIL bounce_busy: busy=%b expected 0001", busy);
                end
            end
            if (i == 10) begin
                checks++;
                if (deb !== 4'b0001 || rise !== 4'b0001 || fall !== 4'b0000 || any !== 1'b1) begin
                    errors++;
                    $display("FAIL bounce_rise: deb=%b rise=%b fall=%b any=%b expected 0001/0001/0000/1",
                             deb, rise, fall, any);
                end
            end
            if (i == 11) begin
                checks++;
                if (deb !== 4'b0001 || rise !== 4'b0000 || any !== 1'b0 || busy !== 4'b0000) begin
                    errors++;
                    $display("FAIL bounce_after: deb=%b rise=%b any=%b busy=%b expected 0001/0000/0/0000",
                             deb, rise, any, busy);
                end
            end
        end
    endtask

    task automatic test_short_pulses();
        bit saw_hi = 0;
        bit saw_lo = 0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 8; c++) begin
                data_in[1] = (c < 7);
                @(negedge clk);
                checks++;
                if (deb !== 4'b0001 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) begin
                    errors++;
                    $display("FAIL short_pulse r=%0d c=%0d: deb=%b rise=%b fall=%b any=%b expected 0001/0000/0000/0",
                             r, c, deb, rise, fall, any);
                end
                if (busy[1]) saw_hi = 1;
                else saw_lo = 1;
            end
        end
        data_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!(saw_hi && saw_lo)) begin
            errors++;
            $display("FAIL short_busy_toggle: saw_hi=%0d saw_lo=%0d expected 1/1", saw_hi, saw_lo);
        end
        checks++;
        if (busy !== 4'b0000) begin
            errors++;
            $display("FAIL short_busy_idle: busy=%b expected 0000", busy);
        end
    endtask

    task automatic test_simultaneous();
        data_in[3:2] = 2'b11;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 9) begin
                checks++;
                if (deb !== 4'b0001 || rise !== 4'b0000) begin
                    errors++;
                    $display("FAIL simul_rise_early: deb=%b rise=%b expected 0001/0000", deb, rise);
                end
            end
            if (i == 10) begin
                checks++;
                if (deb !== 4'b1101 || rise !== 4'b1100 || fall !== 4'b0000 || any !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_rise: deb=%b rise=%b fall=%b any=%b expected 1101/1100/0000/1",
                             deb, rise, fall, any);
                end
            end
            if (i == 11) begin
                checks++;
                if (rise !== 4'b0000 || any !== 1'b0) begin
                    errors++;
                    $display("FAIL simul_rise_end: rise=%b any=%b expected 0000/0", rise, any);
                end
            end
        end
        repeat (3) @(negedge clk);
        data_in[3:2] = 2'b00;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 10) begin
                checks++;
                if (deb !== 4'b0001 || fall !== 4'b1100 || rise !== 4'b0000 || any !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_fall: deb=%b fall=%b rise=%b any=%b expected 0001/1100/0000/1",
                             deb, fall, rise, any);
                end
            end
            if (i == 11) begin
                checks++;
                if (fall !== 4'b0000 || any !== 1'b0) begin
                    errors++;
                    $display("FAIL simul_fall_end: fall=%b any=%b expected 0000/0", fall, any);
                end
            end
        end
    endtask

    task automatic test_reset_midcount();
        data_in[0] = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (deb !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_prep: deb=%b expected 0000", deb);
        end
        data_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_busy: busy=%b expected 0001", busy);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({deb, rise, fall, busy, any} !== 17'd0) begin
            errors++;
            $display("FAIL midrst_async: outputs=%h expected 0", {deb, rise, fall, busy, any});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                checks++;
                if (deb !== 4'b0000 || rise !== 4'b0000) begin
                    errors++;
                    $display("FAIL midrst_requal_early: deb=%b rise=%b expected 0000/0000", deb, rise);
                end
            end
            if (i == 10) begin
                checks++;
                if (deb !== 4'b0001 || rise !== 4'b0001 || any !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_requal: deb=%b rise=%b any=%b expected 0001/0001/1", deb, rise, any);
                end
            end
        end
    endtask

    task automatic test_long_count();
        int lat;
        lat = 0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            #0.5 din2 = ~din2;
        end
        din2 = 1'b1;
        for (int i = 1; i <= LONG_CYCLES + 100; i++) begin
            @(negedge clk);
            if (deb2[0] === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != LONG_CYCLES + 2) begin
            errors++;
            $display("FAIL long_rise_latency: got %0d negedges expected %0d", lat, LONG_CYCLES + 2);
        end
        repeat (5) @(negedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            #0.5 din2 = ~din2;
        end
        din2 = 1'b0;
        lat = 0;
        for (int i = 1; i <= LONG_CYCLES + 100; i++) begin
            @(negedge clk);
            if (deb2[0] === 1'b0) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != LONG_CYCLES + 2) begin
            errors++;
            $display("FAIL long_fall_latency: got %0d negedges expected %0d", lat, LONG_CYCLES + 2);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rise2_cnt != 1 || fall2_cnt != 1) begin
            errors++;
            $display("FAIL long_pulse_count: rise=%0d fall=%0d expected 1/1", rise2_cnt, fall2_cnt);
        end
        checks++;
        if (busy2 !== 1'b0 || any2 !== 1'b0) begin
            errors++;
            $display("FAIL long_idle: busy=%b any=%b expected 0/0", busy2, any2);
        end
    endtask

    initial begin
        test_reset();
        test_bounce_rise();
        test_short_pulses();
        test_simultaneous();
        test_reset_midcount();
        test_long_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
